freq_meas_sched: RTL and testbench

//  Sequences one shared gated edge counter across N_CH input channels. Round-robins over

---
 rtl/freq_meas_sched_if.sv | 40 ++++
 rtl/freq_meas_sched.sv | 200 ++++++++++++++++++++
 tb/tb_freq_meas_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_meas_sched_if.sv
// Host configuration/readback and counter datapath signals of the frequency
// measurement scheduler, grouped so the scheduler has a single bus port.
interface freq_meas_sched_if #(
    parameter int N_CH = 4
) ();
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              cfg_en;
    logic              cfg_single;
    logic [N_CH-1:0]   cfg_ch_mask;
    logic [31:0]       cfg_gate_cycles;

    logic [SEL_W-1:0]  ch_sel;
    logic              cnt_clr;
    logic              cnt_gate;
    logic [63:0]       cnt_value;
    logic              cnt_valid;

    logic [SEL_W-1:0]  rd_ch;
    logic [63:0]       rd_data;
    logic [N_CH-1:0]   res_valid;
    logic [N_CH-1:0]   res_err;
    logic              meas_done;
    logic              pass_done;
    logic              busy;

    modport slave (
        input  cfg_en, cfg_single, cfg_ch_mask, cfg_gate_cycles,
        input  cnt_value, cnt_valid, rd_ch,
        output ch_sel, cnt_clr, cnt_gate, rd_data, res_valid, res_err,
        output meas_done, pass_done, busy
    );

    modport master (
        output cfg_en, cfg_single, cfg_ch_mask, cfg_gate_cycles,
        output cnt_value, cnt_valid, rd_ch,
        input  ch_sel, cnt_clr, cnt_gate, rd_data, res_valid, res_err,
        input  meas_done, pass_done, busy
    );
endinterface

// File: rtl/freq_meas_sched.sv
// Round-robin scheduler sharing one gated edge counter across N_CH channels;
// banks each channel's count (or timeout) for host readback.
module freq_meas_sched #(
    parameter int N_CH        = 4,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             sys_clk_50m,
    input  logic             sys_rst_n,
    freq_meas_sched_if.slave bus
);
    // state  | meaning
    // IDLE   | counter held clear, waiting for cfg_en with a non-empty mask
    // SELECT | pick next enabled channel, latch mask and gate length
    // SETTLE | input mux settling, counter held clear
    // GATE   | counter enabled for the latched gate length
    // WAIT   | gate closed, waiting for cnt_valid or timeout
    // STORE  | bank result, pulse meas_done (and pass_done on last channel)

    localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int N_BANK = 1 << SEL_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_GATE,
        S_WAIT,
        S_STORE
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  ch_q;
    logic [SEL_W-1:0]  pick_ch;
    logic              pick_ok;
    logic [SEL_W-1:0]  last_ch;
    logic              store_last;
    logic [N_CH-1:0]   mask_q;
    logic [31:0]       gate_q;
    logic [31:0]       timer;
    logic [31:0]       timer_ld_val;
    logic              timer_ld;
    logic              timer_zero;
    logic [63:0]       value_q;
    logic              tmo_q;
    logic              single_hold;
    logic              cnt_clr_q;
    logic              cnt_gate_q;
    logic [63:0]       bank [N_BANK];
    logic [N_CH-1:0]   res_valid_q;
    logic [N_CH-1:0]   res_err_q;
    logic [63:0]       rd_q;

    assign timer_zero = (timer == 32'd0);
    assign store_last = (ch_q == last_ch);

    // First enabled channel strictly after the round-robin pointer, with wrap.
    always_comb begin
        int best_d;
        int d;
        best_d  = N_CH;
        d       = 0;
        pick_ch = '0;
        pick_ok = 1'b0;
        for (int j = 0; j < N_CH; j++) begin
            d = (j + 2 * N_CH - int'(rr_ptr) - 1) % N_CH;
            if (bus.cfg_ch_mask[j] && (d < best_d)) begin
                best_d  = d;
                pick_ch = SEL_W'(j);
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        last_ch = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (mask_q[j]) last_ch = SEL_W'(j);
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_ld     = 1'b0;
        timer_ld_val = '0;
        case (state)
            S_IDLE: begin
                if (bus.cfg_en && (|bus.cfg_ch_mask) && !single_hold) state_nxt = S_SELECT;
            end
            S_SELECT: begin
                if (!bus.cfg_en || !pick_ok) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt    = S_SETTLE;
                    timer_ld     = 1'b1;
                    timer_ld_val = 32'(SETTLE_CYC - 1);
                end
            end
            S_SETTLE: begin
                if (!bus.cfg_en) begin
                    state_nxt = S_IDLE;
                end else if (timer_zero) begin
                    state_nxt    = S_GATE;
                    timer_ld     = 1'b1;
                    timer_ld_val = gate_q - 32'd1;
                end
            end
            S_GATE: begin
                if (!bus.cfg_en) begin
                    state_nxt = S_IDLE;
                end else if (timer_zero) begin
                    state_nxt    = S_WAIT;
                    timer_ld     = 1'b1;
                    timer_ld_val = 32'(TIMEOUT_CYC - 1);
                end
            end
            S_WAIT: begin
                if (!bus.cfg_en) state_nxt = S_IDLE;
                else if (bus.cnt_valid || timer_zero) state_nxt = S_STORE;
            end
            S_STORE: begin
                if (!bus.cfg_en || (bus.cfg_single && store_last)) state_nxt = S_IDLE;
                else state_nxt = S_SELECT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= S_IDLE;
            rr_ptr      <= SEL_W'(N_CH - 1);
            ch_q        <= '0;
            mask_q      <= '0;
            gate_q      <= 32'd1;
            timer       <= '0;
            value_q     <= '0;
            tmo_q       <= 1'b0;
            single_hold <= 1'b0;
            cnt_clr_q   <= 1'b1;
            cnt_gate_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            // Counter controls are registered off the next state so they stay glitch-free.
            cnt_clr_q  <= (state_nxt == S_IDLE) || (state_nxt == S_SETTLE);
            cnt_gate_q <= (state_nxt == S_GATE);

            if (timer_ld) timer <= timer_ld_val;
            else if (!timer_zero) timer <= timer - 32'd1;

            if (state == S_IDLE) rr_ptr <= SEL_W'(N_CH - 1);

            if ((state == S_SELECT) && (state_nxt == S_SETTLE)) begin
                ch_q   <= pick_ch;
                rr_ptr <= pick_ch;
                mask_q <= bus.cfg_ch_mask;
                gate_q <= (bus.cfg_gate_cycles == 32'd0) ? 32'd1 : bus.cfg_gate_cycles;
            end

            if ((state == S_WAIT) && (state_nxt == S_STORE)) begin
                value_q <= bus.cnt_valid ? bus.cnt_value : 64'd0;
                tmo_q   <= !bus.cnt_valid;
            end

            // A finished single pass stays parked until the host drops cfg_en.
            if (!bus.cfg_en) single_hold <= 1'b0;
            else if ((state == S_STORE) && bus.cfg_single && store_last) single_hold <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk_50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < N_BANK; i++) bank[i] <= '0;
            res_valid_q <= '0;
            res_err_q   <= '0;
            rd_q        <= '0;
        end else begin
            rd_q <= bank[bus.rd_ch];
            if (state == S_STORE) begin
                bank[ch_q]        <= value_q;
                res_valid_q[ch_q] <= 1'b1;
                res_err_q[ch_q]   <= tmo_q;
            end
        end
    end

    assign bus.ch_sel    = ch_q;
    assign bus.cnt_clr   = cnt_clr_q;
    assign bus.cnt_gate  = cnt_gate_q;
    assign bus.rd_data   = rd_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_err   = res_err_q;
    assign bus.meas_done = (state == S_STORE);
    assign bus.pass_done = (state == S_STORE) && store_last;
    assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_freq_meas_sched.sv
// Self-checking bench for freq_meas_sched: emulated gated counter plus a
// channel-level reference model of the expected results.
module tb_freq_meas_sched;
    localparam int N_CH        = 4;
    localparam int SETTLE_CYC  = 16;
    localparam int TIMEOUT_CYC = 1024;
    localparam int WAIT_LIMIT  = 20000;

    logic sys_clk_50m;
    logic sys_rst_n;

    freq_meas_sched_if #(.N_CH(N_CH)) bus ();

    freq_meas_sched #(
        .N_CH        (N_CH),
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .sys_clk_50m (sys_clk_50m),
        .sys_rst_n   (sys_rst_n),
        .bus         (bus)
    );

    initial begin
        sys_clk_50m = 1'b0;
        forever #10 sys_clk_50m = ~sys_clk_50m;
    end

    int          n_chk;
    int          n_fail;
    longint      freq [N_CH];
    logic [3:0]  withhold;
    logic [63:0] exp_bank [N_CH];
    logic [3:0]  exp_valid;
    logic [3:0]  exp_err;

    int cyc;
    int n_meas;
    int n_pass;
    int sel_q [$];
    int clr_q [$];
    int glen_q [$];
    int dfall_q [$];

    // Monitor: gate windows, clear run before each gate, pulse counts.
    initial begin
        int   clr_run;
        int   glen;
        int   fall_cyc;
        logic gate_prev;
        clr_run = 0; glen = 0; fall_cyc = 0; gate_prev = 1'b0;
        cyc = 0; n_meas = 0; n_pass = 0;
        forever begin
            @(negedge sys_clk_50m);
            cyc++;
            if (!sys_rst_n) begin
                clr_run = 0; glen = 0; gate_prev = 1'b0;
            end else begin
                if (bus.cnt_gate && !gate_prev) begin
                    clr_q.push_back(clr_run);
                    sel_q.push_back(int'(bus.ch_sel));
                    glen = 0;
                end
                if (bus.cnt_gate) glen++;
                if (!bus.cnt_gate && gate_prev) begin
                    glen_q.push_back(glen);
                    fall_cyc = cyc;
                end
                if (bus.meas_done === 1'b1) begin
                    n_meas++;
                    dfall_q.push_back(cyc - fall_cyc);
                end
                if (bus.pass_done === 1'b1) n_pass++;
                clr_run   = (bus.cnt_clr === 1'b1) ? clr_run + 1 : 0;
                gate_prev = bus.cnt_gate;
            end
        end
    end

    // Counter emulation: counts gate cycles, reports count*f/50 after a short random delay.
    initial begin
        int          gcount;
        int          gch;
        int          dly;
        logic        pend;
        logic [63:0] val;
        gcount = 0; gch = 0; dly = 0; pend = 1'b0; val = '0;
        bus.cnt_valid = 1'b0;
        bus.cnt_value = '0;
        forever begin
            @(negedge sys_clk_50m);
            bus.cnt_valid = 1'b0;
            if (pend) begin
                dly--;
                if (dly == 0) begin
                    bus.cnt_valid = 1'b1;
                    bus.cnt_value = val;
                    pend = 1'b0;
                end
            end
            if (bus.cnt_gate === 1'b1) begin
                gcount++;
                gch = int'(bus.ch_sel);
            end else if (gcount != 0) begin
                val    = 64'(longint'(gcount) * freq[gch] / 50);
                gcount = 0;
                if (!withhold[gch]) begin
                    pend = 1'b1;
                    dly  = int'($urandom_range(1, 8));
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < WAIT_LIMIT) begin
            @(negedge sys_clk_50m);
            n++;
        end
        chk({tag, " reaches idle"}, 64'(n < WAIT_LIMIT), 64'd1);
    endtask

    task automatic wait_gate(input string tag);
        int n;
        n = 0;
        while (bus.cnt_gate !== 1'b1 && n < WAIT_LIMIT) begin
            @(negedge sys_clk_50m);
            n++;
        end
        chk({tag, " gate opens"}, 64'(n < WAIT_LIMIT), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus.meas_done !== 1'b1 && n < WAIT_LIMIT) begin
            @(negedge sys_clk_50m);
            n++;
        end
        chk({tag, " meas_done seen"}, 64'(n < WAIT_LIMIT), 64'd1);
    endtask

    task automatic read_bank(input int ch, input string tag);
        bus.rd_ch = 2'(ch);
        @(negedge sys_clk_50m);
        chk($sformatf("%s bank[%0d]", tag, ch), bus.rd_data, exp_bank[ch]);
    endtask

    task automatic clear_logs();
        sel_q.delete();
        clr_q.delete();
        glen_q.delete();
        dfall_q.delete();
    endtask

    // One single pass; expected order is simply the set mask bits in ascending order.
    task automatic run_single(input logic [3:0] mask, input int gate, input logic [3:0] hold,
                              input string tag);
        int     exp_seq [$];
        int     m0;
        int     p0;
        longint eff;
        eff = (gate == 0) ? 1 : longint'(gate);
        for (int c = 0; c < N_CH; c++) if (mask[c]) exp_seq.push_back(c);
        clear_logs();
        m0 = n_meas; p0 = n_pass;
        withhold = hold;
        bus.cfg_single      = 1'b1;
        bus.cfg_ch_mask     = mask;
        bus.cfg_gate_cycles = 32'(gate);
        bus.cfg_en          = 1'b1;
        @(negedge sys_clk_50m);
        chk({tag, " busy rises"}, 64'(bus.busy), 64'd1);
        wait_idle(tag);
        repeat (4) @(negedge sys_clk_50m);
        chk({tag, " stays idle after pass"}, 64'(bus.busy), 64'd0);
        bus.cfg_en = 1'b0;
        chk({tag, " gate count"}, 64'(sel_q.size()), 64'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < sel_q.size() && i < glen_q.size(); i++) begin
            chk($sformatf("%s ch_sel #%0d", tag, i), 64'(sel_q[i]), 64'(exp_seq[i]));
            chk($sformatf("%s settle #%0d", tag, i), 64'(clr_q[i]), 64'(SETTLE_CYC));
            chk($sformatf("%s gate len #%0d", tag, i), 64'(glen_q[i]), 64'(eff));
            if (hold[exp_seq[i]] && i < dfall_q.size())
                chk($sformatf("%s timeout delay #%0d", tag, i), 64'(dfall_q[i]), 64'(TIMEOUT_CYC));
        end
        chk({tag, " meas_done pulses"}, 64'(n_meas - m0), 64'(exp_seq.size()));
        chk({tag, " pass_done pulses"}, 64'(n_pass - p0), 64'd1);
        foreach (exp_seq[i]) begin
            exp_valid[exp_seq[i]] = 1'b1;
            exp_err[exp_seq[i]]   = hold[exp_seq[i]];
            exp_bank[exp_seq[i]]  = hold[exp_seq[i]] ? 64'd0 : 64'(eff * freq[exp_seq[i]] / 50);
        end
        chk({tag, " res_valid"}, 64'(bus.res_valid), 64'(exp_valid));
        chk({tag, " res_err"}, 64'(bus.res_err), 64'(exp_err));
        for (int c = 0; c < N_CH; c++) read_bank(c, tag);
    endtask

    initial begin
        int         m0;
        int         p0;
        longint     g;
        logic [3:0] rmask;
        logic [3:0] rhold;
        int         rgate;

        n_chk = 0; n_fail = 0;
        withhold = '0; exp_valid = '0; exp_err = '0;
        for (int c = 0; c < N_CH; c++) begin
            freq[c]     = 1;
            exp_bank[c] = '0;
        end
        sys_rst_n           = 1'b0;
        bus.cfg_en          = 1'b0;
        bus.cfg_single      = 1'b0;
        bus.cfg_ch_mask     = '0;
        bus.cfg_gate_cycles = '0;
        bus.rd_ch           = '0;

        repeat (3) @(negedge sys_clk_50m);
        chk("reset ch_sel", 64'(bus.ch_sel), 64'd0);
        chk("reset cnt_clr", 64'(bus.cnt_clr), 64'd1);
        chk("reset cnt_gate", 64'(bus.cnt_gate), 64'd0);
        chk("reset rd_data", bus.rd_data, 64'd0);
        chk("reset res_valid", 64'(bus.res_valid), 64'd0);
        chk("reset res_err", 64'(bus.res_err), 64'd0);
        chk("reset meas_done", 64'(bus.meas_done), 64'd0);
        chk("reset pass_done", 64'(bus.pass_done), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk_50m);

        // 1 MHz source, 1000-cycle gate: 20 counts on channels 0 and 2
        run_single(4'b0101, 1000, 4'b0000, "mask0101");

        for (int c = 0; c < N_CH; c++) freq[c] = longint'($urandom_range(50, 250));
        run_single(4'b0010, 5, 4'b0000, "gate5");
        run_single(4'b1001, int'($urandom_range(10, 100)), 4'b0001, "timeout");

        // Abort in the middle of a gate window
        m0 = n_meas;
        bus.cfg_single = 1'b0; bus.cfg_ch_mask = 4'b0100; bus.cfg_gate_cycles = 32'd200;
        bus.cfg_en = 1'b1;
        wait_gate("abort");
        repeat (50) @(negedge sys_clk_50m);
        bus.cfg_en = 1'b0;
        @(negedge sys_clk_50m);
        chk("abort busy", 64'(bus.busy), 64'd0);
        chk("abort cnt_gate", 64'(bus.cnt_gate), 64'd0);
        chk("abort cnt_clr", 64'(bus.cnt_clr), 64'd1);
        repeat (20) @(negedge sys_clk_50m);
        chk("abort no meas_done", 64'(n_meas - m0), 64'd0);
        chk("abort res_valid", 64'(bus.res_valid), 64'(exp_valid));
        read_bank(2, "abort");

        // Continuous on channel 3, frequency changed between measurements
        clear_logs();
        m0 = n_meas; p0 = n_pass; withhold = '0;
        g = longint'($urandom_range(10, 60));
        freq[3] = longint'($urandom_range(50, 250));
        bus.rd_ch = 2'd3;
        bus.cfg_single = 1'b0; bus.cfg_ch_mask = 4'b1000; bus.cfg_gate_cycles = 32'(g);
        bus.cfg_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done("cont");
            chk($sformatf("cont pass_done #%0d", k), 64'(bus.pass_done), 64'd1);
            if (k == 2) bus.cfg_en = 1'b0;
            @(negedge sys_clk_50m);
            chk($sformatf("cont rd old #%0d", k), bus.rd_data, exp_bank[3]);
            exp_bank[3] = 64'(g * freq[3] / 50);
            exp_valid[3] = 1'b1;
            exp_err[3]   = 1'b0;
            freq[3] = longint'($urandom_range(50, 250));
            @(negedge sys_clk_50m);
            chk($sformatf("cont rd new #%0d", k), bus.rd_data, exp_bank[3]);
        end
        wait_idle("cont");
        chk("cont meas_done pulses", 64'(n_meas - m0), 64'd3);
        chk("cont pass_done pulses", 64'(n_pass - p0), 64'd3);
        foreach (sel_q[i]) chk($sformatf("cont ch_sel #%0d", i), 64'(sel_q[i]), 64'd3);

        // Empty mask never leaves idle
        bus.cfg_ch_mask = 4'b0000; bus.cfg_en = 1'b1;
        repeat (30) @(negedge sys_clk_50m);
        chk("mask0 busy", 64'(bus.busy), 64'd0);
        bus.cfg_en = 1'b0;
        @(negedge sys_clk_50m);

        run_single(4'b0001, 0, 4'b0000, "gate0");

        // Mask edit during gate only applies at the next channel pick
        clear_logs();
        m0 = n_meas; p0 = n_pass; withhold = '0;
        bus.cfg_single = 1'b1; bus.cfg_ch_mask = 4'b0011; bus.cfg_gate_cycles = 32'd100;
        bus.cfg_en = 1'b1;
        wait_gate("maskedit");
        repeat (10) @(negedge sys_clk_50m);
        bus.cfg_ch_mask = 4'b0001;
        wait_idle("maskedit");
        repeat (2) @(negedge sys_clk_50m);
        bus.cfg_en = 1'b0;
        chk("maskedit gate count", 64'(sel_q.size()), 64'd2);
        foreach (sel_q[i]) chk($sformatf("maskedit ch_sel #%0d", i), 64'(sel_q[i]), 64'd0);
        chk("maskedit meas_done pulses", 64'(n_meas - m0), 64'd2);
        chk("maskedit pass_done pulses", 64'(n_pass - p0), 64'd1);
        exp_bank[0] = 64'(100 * freq[0] / 50);
        exp_valid[0] = 1'b1;
        exp_err[0]   = 1'b0;
        read_bank(0, "maskedit");

        // Randomized single passes
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < N_CH; c++) freq[c] = longint'($urandom_range(50, 250));
            rmask = 4'($urandom_range(1, 15));
            rgate = int'($urandom_range(0, 40));
            rhold = ($urandom_range(0, 3) == 0) ? (4'($urandom_range(0, 15)) & rmask) : 4'b0000;
            run_single(rmask, rgate, rhold, $sformatf("rand%0d", r));
        end

        // Asynchronous reset in the middle of a measurement
        withhold = '0;
        bus.cfg_single = 1'b0; bus.cfg_ch_mask = 4'b1111; bus.cfg_gate_cycles = 32'd300;
        bus.cfg_en = 1'b1;
        wait_gate("midreset");
        repeat (5) @(negedge sys_clk_50m);
        #3 sys_rst_n = 1'b0;
        #1;
        chk("midreset busy", 64'(bus.busy), 64'd0);
        chk("midreset cnt_gate", 64'(bus.cnt_gate), 64'd0);
        chk("midreset cnt_clr", 64'(bus.cnt_clr), 64'd1);
        chk("midreset ch_sel", 64'(bus.ch_sel), 64'd0);
        chk("midreset res_valid", 64'(bus.res_valid), 64'd0);
        chk("midreset res_err", 64'(bus.res_err), 64'd0);
        chk("midreset rd_data", bus.rd_data, 64'd0);
        chk("midreset meas_done", 64'(bus.meas_done), 64'd0);
        bus.cfg_en = 1'b0;
        @(negedge sys_clk_50m);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk_50m);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
